sample_packetizer: RTL

Frames calibrated CODEC samples into fixed-length byte packets for the `uart_tx` serializer. Sits between the `cal` input path (`cal_in0..3`, `sample_clk`) and `uart_tx`. Each packet carries one decimated 4-channel snapshot, a sequence number and an optional checksum, so host tools can resynchronise, detect drops and plot all channels coherently.

---
 rtl/sample_packetizer_if.sv | 9 +
 rtl/sample_packetizer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/sample_packetizer_if.sv
// Byte-stream handshake between sample_packetizer (master) and uart_tx (slave).
interface sample_packetizer_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    modport master (output tx_start, output tx_data, input tx_busy);
    modport slave  (input tx_start, input tx_data, output tx_busy);
endinterface

// File: rtl/sample_packetizer.sv
// Frames decimated 4-channel sample snapshots into byte packets for uart_tx.
// Define PACKETIZER_CHECKSUM_EN to append an XOR checksum byte (12-byte packets).
module sample_packetizer #(
    parameter int W        = 16,
    parameter int DECIMATE = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_clk,
    input  logic signed [W-1:0] sample_in0,
    input  logic signed [W-1:0] sample_in1,
    input  logic signed [W-1:0] sample_in2,
    input  logic signed [W-1:0] sample_in3,
    sample_packetizer_if.master uart,
    output logic                pkt_active,
    output logic                overrun,
    output logic [7:0]          seq
);

`ifdef PACKETIZER_CHECKSUM_EN
    localparam logic [3:0] LAST_IDX = 4'd11;
`else
    localparam logic [3:0] LAST_IDX = 4'd10;
`endif
    localparam logic [7:0] DEC_LAST = 8'(DECIMATE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    state_t     state, state_nx;
    logic       sclk_q;
    logic       tick;
    logic       due;
    logic       snap;
    logic [7:0] dcnt;
    logic [3:0] bidx;
    logic       bidx_inc;
    logic       tx_start_c;
    logic [7:0] tx_data_q;
    logic [7:0] byte_sel;
    logic [W-1:0] ch0, ch1, ch2, ch3;

    assign tick       = sample_clk & ~sclk_q;
    assign due        = tick && (dcnt == DEC_LAST);
    assign pkt_active = (state != S_IDLE);
    // Snapshots only start from IDLE, so a due snapshot while busy is an overrun.
    assign snap       = due && !pkt_active;

    assign uart.tx_start = tx_start_c;
    assign uart.tx_data  = tx_data_q;

`ifdef PACKETIZER_CHECKSUM_EN
    logic [7:0] csum;
    assign csum = seq ^ ch0[W-1:W-8] ^ ch0[7:0] ^ ch1[W-1:W-8] ^ ch1[7:0]
                      ^ ch2[W-1:W-8] ^ ch2[7:0] ^ ch3[W-1:W-8] ^ ch3[7:0];
`endif

    always_comb begin
        byte_sel = 8'h00;
        case (bidx)
            4'd0:  byte_sel = 8'hA5;
            4'd1:  byte_sel = 8'h5A;
            4'd2:  byte_sel = seq;
            4'd3:  byte_sel = ch0[W-1:W-8];
            4'd4:  byte_sel = ch0[7:0];
            4'd5:  byte_sel = ch1[W-1:W-8];
            4'd6:  byte_sel = ch1[7:0];
            4'd7:  byte_sel = ch2[W-1:W-8];
            4'd8:  byte_sel = ch2[7:0];
            4'd9:  byte_sel = ch3[W-1:W-8];
            4'd10: byte_sel = ch3[7:0];
`ifdef PACKETIZER_CHECKSUM_EN
            4'd11: byte_sel = csum;
`endif
            default: byte_sel = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        tx_start_c = 1'b0;
        bidx_inc   = 1'b0;
        case (state)
            S_IDLE: begin
                if (snap) state_nx = S_LOAD;
            end
            S_LOAD: begin
                if (!uart.tx_busy) state_nx = S_START;
            end
            S_START: begin
                tx_start_c = 1'b1;
                state_nx   = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (uart.tx_busy) state_nx = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (!uart.tx_busy) begin
                    if (bidx == LAST_IDX) begin
                        state_nx = S_IDLE;
                    end else begin
                        state_nx = S_LOAD;
                        bidx_inc = 1'b1;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q    <= 1'b0;
            dcnt      <= '0;
            seq       <= '1;
            overrun   <= 1'b0;
            bidx      <= '0;
            tx_data_q <= '0;
            ch0       <= '0;
            ch1       <= '0;
            ch2       <= '0;
            ch3       <= '0;
        end else begin
            sclk_q <= sample_clk;
            if (tick) begin
                dcnt <= (dcnt == DEC_LAST) ? 8'd0 : dcnt + 8'd1;
            end
            if (due && pkt_active) begin
                overrun <= 1'b1;
            end
            if (snap) begin
                ch0  <= sample_in0;
                ch1  <= sample_in1;
                ch2  <= sample_in2;
                ch3  <= sample_in3;
                seq  <= seq + 8'd1;
                bidx <= '0;
            end else if (bidx_inc) begin
                bidx <= bidx + 4'd1;
            end
            if (state == S_LOAD) begin
                tx_data_q <= byte_sel;
            end
        end
    end

endmodule
